// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory access arbiter.
//   IMEM_ADDR_W  - instruction word address width (RAM depth = 2**IMEM_ADDR_W)
//   IMEM_DATA_W  - instruction width
//   imem_state_e - arbiter FSM state encoding; 2'd3 is illegal and recovers to ST_BOOT
package imem_pkg;

  localparam int unsigned IMEM_ADDR_W = 5;
  localparam int unsigned IMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2
  } imem_state_e;

endpackage

// File: rtl/imem_access_arbiter.sv
// Shares the single port of the writable instruction RAM between the core fetch stage (read)
// and the boot/debug program loader (write). The core is held in reset-like freeze while the
// loader fills the RAM, released on Load_Done, and re-held whenever a later load pre-empts.
//
// Ports:
//   Clk, Reset            - clock; synchronous active-high reset
//   Fetch_Req/Fetch_Addr  - core fetch request and word address
//   Fetch_Valid/Instr     - registered fetch response (latency 1)
//   Core_Hold             - registered; core must freeze its PC
//   Load_Req/Addr/Data    - loader write request
//   Load_Done             - loader finished, release the core
//   Load_Ack              - registered; a write was accepted last cycle
//   Words_Loaded          - saturating count of writes since entering BOOT/LOAD
//   Mem_Addr/WData/WE     - combinational RAM port controls
//   Mem_RData             - combinational RAM read data
module imem_access_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W,
  parameter int unsigned DATA_W = IMEM_DATA_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Fetch_Req,
  input  logic [ADDR_W-1:0] Fetch_Addr,
  output logic              Fetch_Valid,
  output logic [DATA_W-1:0] Fetch_Instr,
  output logic              Core_Hold,
  input  logic              Load_Req,
  input  logic [ADDR_W-1:0] Load_Addr,
  input  logic [DATA_W-1:0] Load_Data,
  input  logic              Load_Done,
  output logic              Load_Ack,
  output logic [ADDR_W:0]   Words_Loaded,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_WData,
  output logic              Mem_WE,
  input  logic [DATA_W-1:0] Mem_RData
);

  localparam logic [ADDR_W:0] CntMax = {1'b1, {ADDR_W{1'b0}}};

  imem_state_e state_q, state_d;
  logic        fetch_grant;
  logic [ADDR_W:0] cnt_d;

  // Loader always wins the port; reset suppresses any partial write.
  assign Mem_WE      = Load_Req & ~Reset;
  assign Mem_Addr    = Load_Req ? Load_Addr : Fetch_Addr;
  assign Mem_WData   = Load_Data;
  assign fetch_grant = (state_q == ST_RUN) & Fetch_Req & ~Load_Req;

  always_comb begin
    state_d = state_q;
    cnt_d   = Words_Loaded;
    unique case (state_q)
      ST_BOOT: if (Load_Done) state_d = ST_RUN;
      ST_RUN:  if (Load_Req)  state_d = ST_LOAD;
      ST_LOAD: if (Load_Done) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase

    if (state_q == ST_RUN && state_d == ST_LOAD) begin
      // Counter restarts on LOAD entry; the pre-empting write is the first word of the load.
      cnt_d = {{ADDR_W{1'b0}}, 1'b1};
    end else if (state_d == ST_BOOT && state_q != ST_BOOT) begin
      cnt_d = '0;
    end else if (Load_Req && Words_Loaded != CntMax) begin
      cnt_d = Words_Loaded + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= ST_BOOT;
      Core_Hold    <= 1'b1;
      Fetch_Valid  <= 1'b0;
      Fetch_Instr  <= '0;
      Load_Ack     <= 1'b0;
      Words_Loaded <= '0;
    end else begin
      state_q      <= state_d;
      Core_Hold    <= (state_d != ST_RUN);
      Fetch_Valid  <= fetch_grant;
      Load_Ack     <= Load_Req;
      Words_Loaded <= cnt_d;
      if (fetch_grant) Fetch_Instr <= Mem_RData;
    end
  end

endmodule

// File: tb/tb_imem_access_arbiter.sv
module tb_imem_access_arbiter;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Fetch_Req;
  logic [AW-1:0] Fetch_Addr;
  logic          Fetch_Valid;
  logic [DW-1:0] Fetch_Instr;
  logic          Core_Hold;
  logic          Load_Req;
  logic [AW-1:0] Load_Addr;
  logic [DW-1:0] Load_Data;
  logic          Load_Done;
  logic          Load_Ack;
  logic [AW:0]   Words_Loaded;
  logic [AW-1:0] Mem_Addr;
  logic [DW-1:0] Mem_WData;
  logic          Mem_WE;
  logic [DW-1:0] Mem_RData;

  int total = 0;
  int bad   = 0;

  // Instruction RAM beside the arbiter: synchronous write, combinational read.
  logic [DW-1:0] mem [2**AW];
  always @(posedge Clk) if (Mem_WE) mem[Mem_Addr] <= Mem_WData;
  assign Mem_RData = mem[Mem_Addr];

  always #5 Clk = ~Clk;

  imem_access_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Fetch_Req    (Fetch_Req),
    .Fetch_Addr   (Fetch_Addr),
    .Fetch_Valid  (Fetch_Valid),
    .Fetch_Instr  (Fetch_Instr),
    .Core_Hold    (Core_Hold),
    .Load_Req     (Load_Req),
    .Load_Addr    (Load_Addr),
    .Load_Data    (Load_Data),
    .Load_Done    (Load_Done),
    .Load_Ack     (Load_Ack),
    .Words_Loaded (Words_Loaded),
    .Mem_Addr     (Mem_Addr),
    .Mem_WData    (Mem_WData),
    .Mem_WE       (Mem_WE),
    .Mem_RData    (Mem_RData)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1; Fetch_Req = 1'b0; Fetch_Addr = '0; Load_Req = 1'b0;
    Load_Addr = '0; Load_Data = '0; Load_Done = 1'b0;
    tick(); tick();
    chk("rst_hold", Core_Hold, 1);
    chk("rst_fvalid", Fetch_Valid, 0);
    chk("rst_finstr", Fetch_Instr, 0);
    chk("rst_ack", Load_Ack, 0);
    chk("rst_words", Words_Loaded, 0);
    Reset = 1'b0;

    // 1: fetch ignored in BOOT, then load and release
    Fetch_Req = 1'b1; Fetch_Addr = 5'h03;
    tick();
    chk("boot_fvalid", Fetch_Valid, 0);
    chk("boot_hold", Core_Hold, 1);
    Fetch_Req = 1'b0;
    Load_Req = 1'b1; Load_Addr = 5'h03; Load_Data = 32'h2001_0003;
    #1;
    chk("boot_we", Mem_WE, 1);
    chk("boot_maddr", Mem_Addr, 5'h03);
    chk("boot_wdata", Mem_WData, 32'h2001_0003);
    tick();
    chk("boot_ack", Load_Ack, 1);
    chk("boot_words1", Words_Loaded, 1);
    Load_Addr = 5'h04; Load_Data = 32'h1357_9BDF;
    tick();
    chk("boot_words2", Words_Loaded, 2);
    Load_Req = 1'b0; Load_Done = 1'b1;
    tick();
    chk("release_hold", Core_Hold, 0);
    chk("release_ack", Load_Ack, 0);
    Load_Done = 1'b0;

    // 2: back-to-back fetches
    Fetch_Req = 1'b1; Fetch_Addr = 5'h03;
    #1;
    chk("run_idle_we", Mem_WE, 0);
    tick();
    chk("f3_valid", Fetch_Valid, 1);
    chk("f3_instr", Fetch_Instr, 32'h2001_0003);
    Fetch_Addr = 5'h04;
    tick();
    chk("f4_valid", Fetch_Valid, 1);
    chk("f4_instr", Fetch_Instr, 32'h1357_9BDF);
    Fetch_Req = 1'b0;
    tick();
    chk("nofetch_valid", Fetch_Valid, 0);
    chk("nofetch_hold", Fetch_Instr, 32'h1357_9BDF);

    // 3: pre-emption
    Fetch_Req = 1'b1; Fetch_Addr = 5'h04;
    Load_Req = 1'b1; Load_Addr = 5'h04; Load_Data = 32'h0022_1818;
    #1;
    chk("pre_we", Mem_WE, 1);
    chk("pre_maddr", Mem_Addr, 5'h04);
    tick();
    chk("pre_fvalid", Fetch_Valid, 0);
    chk("pre_ack", Load_Ack, 1);
    chk("pre_hold", Core_Hold, 1);
    chk("pre_instr_kept", Fetch_Instr, 32'h1357_9BDF);
    Load_Req = 1'b0;
    tick();
    chk("load_fetch_ignored", Fetch_Valid, 0);
    chk("load_hold", Core_Hold, 1);
    chk("load_words", Words_Loaded, 1);
    Fetch_Req = 1'b0; Load_Done = 1'b1;
    tick();
    chk("load_release", Core_Hold, 0);
    Load_Done = 1'b0; Fetch_Req = 1'b1; Fetch_Addr = 5'h04;
    tick();
    chk("f4_new_valid", Fetch_Valid, 1);
    chk("f4_new_instr", Fetch_Instr, 32'h0022_1818);
    Fetch_Req = 1'b0;

    // 6: Load_Req + Load_Done together in LOAD
    Load_Req = 1'b1; Load_Addr = 5'h08; Load_Data = 32'h0000_0011;
    tick();
    chk("l6_hold", Core_Hold, 1);
    Load_Addr = 5'h07; Load_Data = 32'h0800_000F; Load_Done = 1'b1;
    #1;
    chk("l6_we", Mem_WE, 1);
    tick();
    chk("l6_ack", Load_Ack, 1);
    chk("l6_hold_rel", Core_Hold, 0);
    chk("l6_words", Words_Loaded, 2);
    Load_Req = 1'b0; Load_Done = 1'b0; Fetch_Req = 1'b1; Fetch_Addr = 5'h07;
    tick();
    chk("f7_valid", Fetch_Valid, 1);
    chk("f7_instr", Fetch_Instr, 32'h0800_000F);
    Fetch_Req = 1'b0;

    // 5: reset during LOAD with a pending write
    Load_Req = 1'b1; Load_Addr = 5'h09; Load_Data = 32'h0000_AAAA;
    tick();
    Reset = 1'b1; Load_Addr = 5'h03; Load_Data = 32'hDEAD_BEEF;
    #1;
    chk("rst_we_blocked", Mem_WE, 0);
    tick();
    Reset = 1'b0; Load_Req = 1'b0;
    chk("rst2_hold", Core_Hold, 1);
    chk("rst2_fvalid", Fetch_Valid, 0);
    chk("rst2_finstr", Fetch_Instr, 0);
    chk("rst2_ack", Load_Ack, 0);
    chk("rst2_words", Words_Loaded, 0);
    chk("rst2_ram3", mem[3], 32'h2001_0003);
    Load_Done = 1'b1;
    tick();
    Load_Done = 1'b0; Fetch_Req = 1'b1; Fetch_Addr = 5'h03;
    tick();
    chk("rst2_f3", Fetch_Instr, 32'h2001_0003);
    Fetch_Req = 1'b0;

    // 4: saturation and wrap in BOOT
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      Load_Req = 1'b1; Load_Addr = AW'(i); Load_Data = 32'(i);
      if (i == 32) begin
        #1;
        chk("wrap_maddr", Mem_Addr, 5'h00);
      end
      tick();
      if (i == 30) chk("sat_words31", Words_Loaded, 31);
      if (i == 31) chk("sat_words32", Words_Loaded, 32);
    end
    Load_Req = 1'b0;
    chk("sat_words40", Words_Loaded, 32);
    chk("wrap_ram0", mem[0], 32'd32);
    chk("wrap_ram7", mem[7], 32'd39);
    chk("sat_hold", Core_Hold, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
